// File: rtl/attn_sched_pkg.sv
// Shared types and helpers for the attention-score burst scheduler.
// Round-robin search and FSM encoding live here so the top and any checker agree on them.
package attn_sched_pkg;

  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 32;
  localparam int TAG_D_DEF = 8;
  localparam int RR_MAXN   = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_res_t;

  // First set bit of req at or above ptr, wrapping at n. The loop runs from the
  // far end back towards ptr so the last hit written is the highest-priority one.
  function automatic rr_res_t rr_first(input logic [15:0] req, input logic [3:0] ptr,
                                       input int n);
    rr_res_t res;
    int      idx;
    res = '0;
    for (int k = RR_MAXN - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[3:0]]) begin
          res.found = 1'b1;
          res.idx   = idx[3:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/attn_tag_fifo.sv
// In-order FIFO of source IDs for beats sent to the shared unit.
// Head is read from registered storage; full/empty come from the registered count.
module attn_tag_fifo
  import attn_sched_pkg::*;
#(
  parameter int W = 2,
  parameter int D = TAG_D_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0] mem_q [D];
  logic [W-1:0] mem_d [D];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW + 1)'(D));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/attn_score_burst_sched.sv
// Round-robin burst scheduler sharing one pipelined score unit among N row engines.
// Accepted beats are tagged in order so unit results can be steered back to their owner.
module attn_score_burst_sched
  import attn_sched_pkg::*;
#(
  parameter int  N     = N_DEF,
  parameter int  DW    = DW_DEF,
  parameter int  TAG_D = TAG_D_DEF,
  localparam int IDW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            unit_in_valid,
  input  logic            unit_in_ready,
  output logic [DW-1:0]   unit_in_data,
  output logic [IDW-1:0]  unit_in_src,
  input  logic            unit_out_valid,
  input  logic [DW-1:0]   unit_out_data,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            busy,
  output logic            err_orphan
);

  // Handshake: a beat moves when valid and ready are both high on a rising edge.
  // unit_in_valid never looks at unit_in_ready; req_ready is ready-through from the unit.

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            err_orphan_q, err_orphan_d;

  logic            locked;
  logic            owner_valid;
  logic            owner_last;
  logic            xfer;
  logic            tag_full;
  logic            tag_empty;
  logic            tag_pop;
  logic [IDW-1:0]  tag_head;
  logic [15:0]     req_ext;
  logic [3:0]      ptr_ext;
  rr_res_t         rr;

  assign locked = (state_q == ST_LOCK);

  always_comb begin
    owner_valid  = 1'b0;
    owner_last   = 1'b0;
    unit_in_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == IDW'(i)) begin
        owner_valid  = req_valid[i];
        owner_last   = req_last[i];
        unit_in_data = req_data[i*DW +: DW];
      end
    end
  end

  assign unit_in_valid = locked & owner_valid & ~tag_full;
  assign unit_in_src   = owner_q;
  assign xfer          = unit_in_valid & unit_in_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = locked & (owner_q == IDW'(i)) & unit_in_ready & ~tag_full;
    end
  end

  always_comb begin
    req_ext            = '0;
    req_ext[N-1:0]     = req_valid;
    ptr_ext            = '0;
    ptr_ext[IDW-1:0]   = ptr_q;
    rr                 = rr_first(req_ext, ptr_ext, N);
  end

  // The grant is held until the owner's last beat moves; a dropped valid only stalls.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (rr.found) begin
          owner_d = rr.idx[IDW-1:0];
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (xfer && owner_last) begin
          ptr_d   = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tag_pop = unit_out_valid & ~tag_empty;

  always_comb begin
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    err_orphan_d = err_orphan_q | (unit_out_valid & tag_empty);
    if (tag_pop) begin
      rsp_valid_d = {{(N - 1){1'b0}}, 1'b1} << tag_head;
      rsp_data_d  = unit_out_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err_orphan = err_orphan_q;
  assign busy       = locked | ~tag_empty;

  attn_tag_fifo #(
    .W (IDW),
    .D (TAG_D)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (xfer),
    .pop   (tag_pop),
    .din   (owner_q),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

endmodule

// File: doc/attn_score_burst_sched.md
Name: attn_score_burst_sched

Overview:
- Shares one pipelined FP32 attention-score compute unit among N requesters (query-row engines).
- Each requester sends multi-beat bursts (QK^T row chunks). The scheduler grants one requester per burst in round-robin order and locks the grant until the last beat.
- It tags every accepted beat with its source ID in an in-order tag FIFO, then routes unit results back to the owning requester.
- Sits between the per-row request queues and the shared score datapath.

Parameters:
- N, 4, number of requesters (2..16)
- DW, 32, beat data width (FP32)
- TAG_D, 8, tag FIFO depth; power of two, at least unit latency + 1
- IDW, $clog2(N), derived source-ID width; not overridable

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester beat valid
- req_last  in  N  per-requester last-beat-of-burst flag
- req_data  in  N*DW  per-requester beat data; slice i = [i*DW +: DW]
- req_ready  out  N  per-requester beat accepted
- unit_in_valid  out  1  beat to shared unit
- unit_in_ready  in  1  shared unit can accept
- unit_in_data  out  DW  forwarded beat
- unit_in_src  out  IDW  owner ID (debug/trace)
- unit_out_valid  in  1  result from unit; in order, no backpressure
- unit_out_data  in  DW  result data
- rsp_valid  out  N  one-hot result strobe
- rsp_data  out  DW  result data, broadcast to all requesters
- busy  out  1  state==LOCK or tag FIFO non-empty
- err_orphan  out  1  sticky: result arrived with the tag FIFO empty

Behaviour:
- Reset values: state=IDLE, ptr=0, owner=0, tag FIFO empty, rsp_valid=0, rsp_data=0, err_orphan=0, all req_ready=0, unit_in_valid=0.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - If |req_valid, set owner = first i with req_valid[i], searching upward from ptr with wrap (ptr has priority), and go to LOCK.
  - No beat transfers in IDLE, so each burst costs one arbitration bubble cycle.
- LOCK:
  - unit_in_valid = req_valid[owner] & ~tag_full.
  - req_ready[i] = (i==owner) & unit_in_ready & ~tag_full; all other ready bits are 0.
  - unit_in_data = req_data slice owner; unit_in_src = owner.
  - A transfer (xfer) = unit_in_valid & unit_in_ready. Each xfer pushes owner into the tag FIFO.
  - On an xfer with req_last[owner]=1: ptr <= (owner+1) mod N, go to IDLE.
  - While locked, the owner dropping req_valid only stalls; the grant is not released without a last beat.
- Combinational paths: req_ready depends combinationally on unit_in_ready. unit_in_valid must not depend on unit_in_ready.
- Response path:
  - On unit_out_valid with the FIFO non-empty: pop head h. Next cycle rsp_valid = one-hot(h) and rsp_data = unit_out_data (1-cycle registered latency).
  - Otherwise rsp_valid=0 next cycle; rsp_data holds its last value.
- Boundary conditions:
  - tag_full blocks a push even if a pop happens in the same cycle (full is the registered count). A push and pop when not full are both honoured; count is unchanged.
  - unit_out_valid with the FIFO empty: no pop, rsp_valid=0, err_orphan <= 1 until reset.
  - Single-beat burst (req_last on the first beat) is legal: IDLE, LOCK, IDLE.
  - ptr wrap: owner=N-1 finishing gives ptr=0.
  - Reset mid-burst or with tags in flight: everything returns to reset values immediately. Results in flight after reset are treated as orphans.
- Fairness: with all requesters continuously valid and bursts of length L, grant order is 0,1,...,N-1,0. Each requester gets L beats per N*(L+1) cycles when unit_in_ready=1.

Decomposition:
- Package attn_sched_pkg:
  - state enum {ST_IDLE, ST_LOCK}
  - function rr_first(req, ptr) returning index and found flag
  - localparam default N/DW/TAG_D
- Sub-module attn_tag_fifo:
  - Parameters: width IDW, depth TAG_D
  - Ports: push, pop, din, dout, full, empty
  - Synchronous-read head, asynchronous reset

Test Plan:
- Requester 2 alone sends a 3-beat burst (data 0x3F800000, 0x40000000, 0x40400000), unit latency 4 -> unit_in_valid in cycles 1-3 after grant; rsp_valid=4'b0100 for 3 cycles with matching data; busy then drops.
- All 4 requesters valid with 2-beat bursts and ptr=0 -> grant order 0,1,2,3,0; each burst is preceded by one IDLE bubble.
- unit_in_ready=0 for 5 cycles mid-burst -> req_ready[owner]=0, no push, owner unchanged; the burst resumes when ready returns to 1.
- Unit returns no results for 8 accepted beats (TAG_D=8) -> tag_full; unit_in_valid=0 and req_ready=0. After one unit_out_valid the next cycle allows a push.
- unit_out_valid pulse with the FIFO empty -> err_orphan=1, rsp_valid=0, stays set until rst_n is asserted.
- rst_n asserted during burst beat 2 of requester 1 -> all outputs at reset values; after release, requester 3 alone gets the grant (ptr=0 scan).
